// File: rtl/multi_pt_rotator.sv
// multi_pt_rotator: rotates NUM_PTS base points by a 15-degree-step angle through one shared
// two-stage pipe and commits the whole set atomically to display registers driving a dot-hit output.
module multi_pt_rotator #(
    parameter int NUM_PTS  = 8,
    parameter int COORD_W  = 10,
    parameter int CX       = 320,
    parameter int CY       = 240,
    parameter int DOT_HALF = 1,
    localparam int IW = $clog2(NUM_PTS)
) (
    input  logic                      clk_100MHz,
    input  logic                      rst_n,
    input  logic                      video_on_pt,
    input  logic [COORD_W-1:0]        x_pt,
    input  logic [COORD_W-1:0]        y_pt,
    input  logic                      dots_en,
    input  logic                      ld_valid,
    input  logic [IW-1:0]             ld_idx,
    input  logic signed [COORD_W-1:0] ld_x,
    input  logic signed [COORD_W-1:0] ld_y,
    input  logic                      step_ccw,
    input  logic                      step_cw,
    output logic                      busy,
    output logic                      done,
    output logic [4:0]                angle_idx,
    output logic                      dots
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, COMMIT} state_t;
    localparam int PW = COORD_W + 10;

    state_t state_q, state_d;
    logic [4:0] angle_q, angle_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic signed [COORD_W-1:0] base_x_q [NUM_PTS];
    logic signed [COORD_W-1:0] base_y_q [NUM_PTS];
    logic [COORD_W-1:0] sh_x_q [NUM_PTS];
    logic [COORD_W-1:0] sh_y_q [NUM_PTS];
    logic [COORD_W-1:0] disp_x_q [NUM_PTS];
    logic [COORD_W-1:0] disp_y_q [NUM_PTS];
    logic s1_v_q;
    logic [IW-1:0] s1_idx_q;
    logic signed [PW-1:0] p_xc_q, p_ys_q, p_xs_q, p_yc_q;
    logic done_q, dots_q;
    logic signed [9:0] cos_v, sin_v;
    logic signed [PW:0] sum_x, sum_y;
    logic [COORD_W-1:0] scr_x, scr_y;
    logic ld_ok, req, hit;

    // First-quadrant table; the other quadrants follow by symmetry.
    function automatic logic signed [9:0] q1(input logic [2:0] r);
        case (r)
            3'd0: q1 = 10'sd256;
            3'd1: q1 = 10'sd247;
            3'd2: q1 = 10'sd222;
            3'd3: q1 = 10'sd181;
            3'd4: q1 = 10'sd128;
            3'd5: q1 = 10'sd66;
            default: q1 = 10'sd0;
        endcase
    endfunction

    function automatic logic signed [9:0] cos_lut(input logic [4:0] k);
        cos_lut = (k <= 5'd6)  ? q1(3'(k)) :
                  (k <= 5'd12) ? -q1(3'(5'd12 - k)) :
                  (k <= 5'd18) ? -q1(3'(k - 5'd12)) : q1(3'(5'd24 - k));
    endfunction

    assign cos_v = cos_lut(angle_q);
    assign sin_v = cos_lut((angle_q >= 5'd6) ? angle_q - 5'd6 : angle_q + 5'd18);
    assign ld_ok = (state_q == IDLE) && ld_valid && ({1'b0, ld_idx} < (IW+1)'(NUM_PTS));
    assign req   = (state_q == IDLE) && (step_ccw || step_cw);

    always_comb begin
        state_d = state_q;
        angle_d = angle_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (req) begin
                state_d = ISSUE;
                cnt_d   = '0;
                angle_d = (step_ccw && step_cw) ? angle_q :
                          step_ccw ? ((angle_q == 5'd23) ? 5'd0 : angle_q + 5'd1) :
                                     ((angle_q == 5'd0) ? 5'd23 : angle_q - 5'd1);
            end
            ISSUE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == IW'(NUM_PTS - 1)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == IW'(1)) state_d = COMMIT;
            end
            default: state_d = IDLE;
        endcase
    end

    // Round-to-nearest via +128 before the arithmetic shift; wrap onto the screen offset.
    assign sum_x = (PW+1)'(p_xc_q) - (PW+1)'(p_ys_q) + (PW+1)'(128);
    assign sum_y = (PW+1)'(p_xs_q) + (PW+1)'(p_yc_q) + (PW+1)'(128);
    assign scr_x = COORD_W'(sum_x >>> 8) + COORD_W'(CX);
    assign scr_y = COORD_W'(sum_y >>> 8) + COORD_W'(CY);

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NUM_PTS; i++)
            hit = hit |
                (({1'b0, x_pt} + (COORD_W+1)'(DOT_HALF) >= {1'b0, disp_x_q[i]}) &&
                 ({1'b0, x_pt} < {1'b0, disp_x_q[i]} + (COORD_W+1)'(DOT_HALF)) &&
                 ({1'b0, y_pt} + (COORD_W+1)'(DOT_HALF) >= {1'b0, disp_y_q[i]}) &&
                 ({1'b0, y_pt} < {1'b0, disp_y_q[i]} + (COORD_W+1)'(DOT_HALF)));
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            angle_q  <= '0;
            cnt_q    <= '0;
            s1_v_q   <= 1'b0;
            s1_idx_q <= '0;
            p_xc_q   <= '0;
            p_ys_q   <= '0;
            p_xs_q   <= '0;
            p_yc_q   <= '0;
            done_q   <= 1'b0;
            dots_q   <= 1'b0;
            for (int i = 0; i < NUM_PTS; i++) begin
                base_x_q[i] <= '0;
                base_y_q[i] <= '0;
                sh_x_q[i]   <= COORD_W'(CX);
                sh_y_q[i]   <= COORD_W'(CY);
                disp_x_q[i] <= COORD_W'(CX);
                disp_y_q[i] <= COORD_W'(CY);
            end
        end else begin
            state_q  <= state_d;
            angle_q  <= angle_d;
            cnt_q    <= cnt_d;
            if (ld_ok) begin
                base_x_q[ld_idx] <= ld_x;
                base_y_q[ld_idx] <= ld_y;
            end
            s1_v_q   <= (state_q == ISSUE);
            s1_idx_q <= cnt_q;
            p_xc_q   <= base_x_q[cnt_q] * cos_v;
            p_ys_q   <= base_y_q[cnt_q] * sin_v;
            p_xs_q   <= base_x_q[cnt_q] * sin_v;
            p_yc_q   <= base_y_q[cnt_q] * cos_v;
            if (s1_v_q) begin
                sh_x_q[s1_idx_q] <= scr_x;
                sh_y_q[s1_idx_q] <= scr_y;
            end
            if (state_q == COMMIT) begin
                disp_x_q <= sh_x_q;
                disp_y_q <= sh_y_q;
            end
            done_q <= (state_q == COMMIT);
            dots_q <= hit && dots_en && video_on_pt;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign angle_idx = angle_q;
    assign dots      = dots_q;
endmodule

// File: tb/tb_multi_pt_rotator.sv
// tb_multi_pt_rotator: directed steps with a scoreboard of expected angle/point-0 screen position per request.
module tb_multi_pt_rotator;
    logic clk = 0, rst_n = 0, video_on = 0, dots_en = 0, ld_valid = 0, step_ccw = 0, step_cw = 0;
    logic [9:0] x_pt = 0, y_pt = 0;
    logic [2:0] ld_idx = 0;
    logic signed [9:0] ld_x = 0, ld_y = 0;
    logic busy, done, dots, busy_b, done_b, dots_b;
    logic [4:0] angle, angle_b;
    int checks = 0, errors = 0;
    int ang_m = 0, p0x = 0, p0y = 0;
    typedef struct {int ang; int sx; int sy;} exp_t;
    exp_t sb[$];

    multi_pt_rotator dut (
        .clk_100MHz(clk), .rst_n(rst_n), .video_on_pt(video_on), .x_pt(x_pt), .y_pt(y_pt),
        .dots_en(dots_en), .ld_valid(ld_valid), .ld_idx(ld_idx), .ld_x(ld_x), .ld_y(ld_y),
        .step_ccw(step_ccw), .step_cw(step_cw), .busy(busy), .done(done), .angle_idx(angle), .dots(dots)
    );

    multi_pt_rotator #(.NUM_PTS(5)) dut_b (
        .clk_100MHz(clk), .rst_n(rst_n), .video_on_pt(video_on), .x_pt(x_pt), .y_pt(y_pt),
        .dots_en(dots_en), .ld_valid(ld_valid), .ld_idx(ld_idx), .ld_x(ld_x), .ld_y(ld_y),
        .step_ccw(step_ccw), .step_cw(step_cw), .busy(busy_b), .done(done_b), .angle_idx(angle_b), .dots(dots_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic void rot(input int x, input int y, input int k, output int sx, output int sy);
        real a;
        int c, s;
        a = k * 15.0 * 3.14159265358979 / 180.0;
        c = int'(256.0 * $cos(a));
        s = int'(256.0 * $sin(a));
        sx = (((x * c - y * s + 128) >>> 8) + 320) & 1023;
        sy = (((x * s + y * c + 128) >>> 8) + 240) & 1023;
    endfunction

    task automatic probe(input string tag, input int px, input int py, input logic en, input logic vid, input logic exp_v);
        @(negedge clk);
        x_pt = 10'(px); y_pt = 10'(py); dots_en = en; video_on = vid;
        @(posedge clk); #1;
        chk(tag, 32'(dots), 32'(exp_v));
    endtask

    task automatic pin(input string tag, input int px, input int py);
        probe({tag, " on"}, px, py, 1, 1, 1);
        probe({tag, " x+1"}, px + 1, py, 1, 1, 0);
        probe({tag, " y+1"}, px, py + 1, 1, 1, 0);
    endtask

    task automatic start(input logic ccw, input logic cw, input logic do_ld, input int idx, input int lx, input int ly);
        exp_t e;
        @(negedge clk);
        step_ccw = ccw; step_cw = cw; ld_valid = do_ld; ld_idx = 3'(idx); ld_x = 10'(lx); ld_y = 10'(ly);
        @(posedge clk); #1;
        step_ccw = 0; step_cw = 0; ld_valid = 0;
        chk("busy after accept", 32'(busy), 1);
        if (ccw && !cw) ang_m = (ang_m + 1) % 24;
        if (cw && !ccw) ang_m = (ang_m + 23) % 24;
        if (do_ld && idx == 0) begin p0x = lx; p0y = ly; end
        e.ang = ang_m;
        rot(p0x, p0y, ang_m, e.sx, e.sy);
        sb.push_back(e);
    endtask

    task automatic finish_step(input string tag, input int exp_n);
        int n = 0;
        exp_t e;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done && n < 40);
        chk({tag, " latency"}, 32'(n), 32'(exp_n));
        e = sb.pop_front();
        chk({tag, " angle"}, 32'(angle), 32'(e.ang));
        pin({tag, " pt0"}, e.sx, e.sy);
    endtask

    initial begin
        int sx, sy, seen;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset angle", 32'(angle), 0);
        chk("reset dots", 32'(dots), 0);
        @(negedge clk) rst_n = 1;
        pin("reset display", 320, 240);

        // Load lands in the same cycle as the refresh and is used by it.
        start(1, 1, 1, 0, -50, -50);
        finish_step("refresh", 11);
        probe("lower edge", 269, 190, 1, 1, 1);
        probe("past upper edge", 272, 190, 1, 1, 0);
        probe("lag on", 270, 190, 1, 1, 1);
        @(negedge clk);
        x_pt = 10'd272;
        #1 chk("lag holds", 32'(dots), 1);
        @(posedge clk); #1;
        chk("lag off", 32'(dots), 0);
        probe("dots_en low", 270, 190, 0, 1, 0);
        probe("video off", 270, 190, 1, 0, 0);

        start(1, 0, 0, 0, 0, 0);
        finish_step("ccw1", 11);
        pin("ccw1 literal", 285, 179);
        for (int i = 0; i < 23; i++) begin
            start(1, 0, 0, 0, 0, 0);
            finish_step("ccw loop", 11);
        end
        chk("full turn angle", 32'(angle), 0);
        pin("no drift", 270, 190);

        // Step and load during busy must be dropped.
        start(0, 1, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        step_ccw = 1; ld_valid = 1; ld_idx = 0; ld_x = 0; ld_y = 0;
        @(posedge clk); #1;
        step_ccw = 0; ld_valid = 0;
        finish_step("cw wrap", 7);
        chk("cw wrap angle", 32'(angle), 23);
        start(1, 1, 0, 0, 0, 0);
        finish_step("base kept", 11);

        // Index 5 is valid for the 8-point instance, out of range for the 5-point one.
        start(1, 1, 1, 5, 100, 100);
        finish_step("idx5", 11);
        rot(100, 100, ang_m, sx, sy);
        probe("idx5 loaded", sx, sy, 1, 1, 1);
        chk("idx5 ignored small", 32'(dots_b), 0);
        chk("small angle", 32'(angle_b), 32'(ang_m));

        start(1, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("mid reset busy", 32'(busy), 0);
        chk("mid reset angle", 32'(angle), 0);
        chk("mid reset done", 32'(done), 0);
        sb.delete();
        ang_m = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            seen = seen | 32'(done);
        end
        chk("no done after reset", 32'(seen), 0);
        pin("reset display again", 320, 240);
        probe("old pt0 gone", sx, sy, 1, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
